lwir_compression_ctrl: RTL
==========================

Name: lwir_compression_ctrl

Overview:
- Frame-level sequencer that wraps the LWIR lossless compression core.
- Arms one frame per `start` pulse, clears the core's context between frames, and gates exactly IMG_W*IMG_H sensor pixels into it.
- Frames the core's 32-bit output as: header word, compressed payload, trailer.
- Sits between the sensor pixel source and the packet/DMA writer.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 512, lines per frame.
- DRAIN_CYCLES, 16, consecutive idle cycles of cmp_valid_out that declare the core empty.
- CLEAR_CYCLES, 2, cycles cmp_rst is held high before each frame.
- MAGIC, 16'h4C57, header sync pattern.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; arms one frame.
- src_valid  in  1  sensor pixel valid.
- src_pixel  in  16  sensor pixel.
- src_ready  out  1  controller accepts a pixel when src_valid & src_ready.
- cmp_rst  out  1  active-high reset to the compression core.
- cmp_valid_in  out  1  pixel strobe to the core.
- cmp_pixel_in  out  16  pixel to the core.
- cmp_valid_out  in  1  core output valid.
- cmp_stream_out  in  32  core output word.
- out_valid  out  1  framed stream valid.
- out_data  out  32  framed stream word.
- out_sof  out  1  marks the header word.
- out_eof  out  1  marks the last trailer word.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  count of completed frames; wraps at 16'hFFFF -> 0.
- err_stray  out  1  sticky; set by core output arriving outside STREAM/DRAIN.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; cmp_rst=1; every other output 0; frame_cnt=0; all counters 0; err_stray=0. Reset mid-frame aborts the frame immediately and emits no trailer.
- IDLE: cmp_rst=0. `start`=1 -> CLEAR on the next edge. `start` in any other state is ignored.
- CLEAR: cmp_rst=1 for CLEAR_CYCLES cycles, then HEADER.
- HEADER: one cycle. Registered output word {MAGIC, frame_cnt} with out_valid=1 and out_sof=1. Next state STREAM.
- STREAM:
  - src_ready = (state==STREAM), combinational from state.
  - Each accepted pixel is registered to cmp_pixel_in / cmp_valid_in with 1-cycle latency. cmp_valid_in is 0 in all other cycles.
  - pix_cnt runs from 0 to IMG_W*IMG_H-1, width $clog2(IMG_W*IMG_H).
  - Accepting the pixel at pix_cnt==IMG_W*IMG_H-1 -> DRAIN. src_ready is low from the next cycle.
- STREAM and DRAIN output path:
  - out_valid/out_data = cmp_valid_out/cmp_stream_out, registered (1-cycle latency).
  - pay_cnt (32-bit, saturating at 32'hFFFFFFFF) increments per forwarded word.
- DRAIN: idle_cnt resets to 0 on any cmp_valid_out and otherwise increments. idle_cnt==DRAIN_CYCLES-1 with no valid this cycle -> TRAILER.
- TRAILER: one cycle (see Optional Feature). Emits pay_cnt with out_valid=1 and out_eof=1. Then frame_cnt++, pay_cnt=0, return to IDLE.
- cmp_valid_out in IDLE/CLEAR/HEADER/TRAILER: word dropped, err_stray=1 (cleared only by reset). Header and trailer never collide with payload.
- src_valid while src_ready=0: ignored, nothing consumed.
- No output backpressure; the downstream must accept one word per cycle.

Optional Feature:
- Macro: LWIR_CTRL_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of forwarded payload words is kept.
  - TRAILER lasts 2 cycles: word 1 = pay_cnt (out_eof=0), word 2 = sum (out_eof=1).
- Undefined: single trailer word = pay_cnt with out_eof=1; no sum register.

Decomposition:
- Package lwir_ctrl_pkg: state enum (IDLE, CLEAR, HEADER, STREAM, DRAIN, TRAILER), MAGIC default, header field bit positions ([31:16] magic, [15:0] frame number).
- One sub-module: lwir_idle_timer, the DRAIN_CYCLES consecutive-idle counter with clear and done outputs. Everything else stays flat.

Test Plan (IMG_W=4, IMG_H=2, DRAIN_CYCLES=4, CLEAR_CYCLES=2; behavioural core model emits one word per 2 pixels with 3-cycle latency):
- Reset with start held high -> all outputs 0 and cmp_rst=1 during reset; busy=0 after release until start is pulsed.
- start pulse, 8 pixels 0x0100..0x0107 -> cmp_rst high 2 cycles; header 0x4C570000 with sof; exactly 8 cmp_valid_in strobes; 4 payload words forwarded; trailer 0x00000004 with eof; frame_cnt=1.
- src_valid toggled every other cycle -> exactly 8 pixels accepted; src_ready drops the cycle after the 8th; a 9th src_valid is not consumed.
- Core model bursts words with gaps of 3 idle cycles during DRAIN -> no premature TRAILER; trailer appears 4 idle cycles after the last word.
- cmp_valid_out forced high in IDLE -> no out_valid; err_stray=1 and stays set through the next frame.
- rst asserted mid-STREAM after 5 pixels, then restart -> no trailer emitted; new header carries frame number 0x0000. With LWIR_CTRL_CHECKSUM_EN defined, trailer word 2 = sum of the 4 payload words.

Source files
------------

// File: rtl/lwir_ctrl_pkg.sv
// Shared types and constants for the LWIR compression frame controller.
// Holds the FSM state encoding and the header word layout.
package lwir_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    HEADER  = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    TRAILER = 3'd5
  } ctrl_state_t;

  localparam logic [15:0] MAGIC_DEFAULT = 16'h4C57;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_FRAME_MSB = 15;
  localparam int HDR_FRAME_LSB = 0;

  function automatic logic [31:0] make_header(input logic [15:0] magic,
                                              input logic [15:0] frame);
    logic [31:0] word;
    word = '0;
    word[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = magic;
    word[HDR_FRAME_MSB:HDR_FRAME_LSB] = frame;
    return word;
  endfunction

endpackage

// File: rtl/lwir_idle_timer.sv
// Counts consecutive idle cycles of the core output; done fires on the
// DRAIN_CYCLES-th idle cycle in a row while enabled.
module lwir_idle_timer #(
  parameter int DRAIN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic valid,
  output logic done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(DRAIN_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      idle_cnt_reg <= '0;
    end else if (enable) begin
      if (valid) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != LAST_IDLE) begin
        idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign done = enable && !valid && (idle_cnt_reg == LAST_IDLE);

endmodule

// File: rtl/lwir_compression_ctrl.sv
// Frame sequencer around the LWIR lossless compression core: header, payload, trailer.
// Define LWIR_CTRL_CHECKSUM_EN to append a payload checksum word to the trailer.
module lwir_compression_ctrl
  import lwir_ctrl_pkg::*;
#(
  parameter int          IMG_W        = 640,
  parameter int          IMG_H        = 512,
  parameter int          DRAIN_CYCLES = 16,
  parameter int          CLEAR_CYCLES = 2,
  parameter logic [15:0] MAGIC        = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_valid,
  input  logic [15:0] src_pixel,
  output logic        src_ready,
  output logic        cmp_rst,
  output logic        cmp_valid_in,
  output logic [15:0] cmp_pixel_in,
  input  logic        cmp_valid_out,
  input  logic [31:0] cmp_stream_out,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_stray
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [CLR_W-1:0] LAST_CLR  = CLR_W'(CLEAR_CYCLES - 1);

  ctrl_state_t state_reg, state_next;

  logic [CLR_W-1:0] clr_cnt_reg;
  logic [PIX_W-1:0] pix_cnt_reg;
  logic [31:0]      pay_cnt_reg;
  logic [15:0]      frame_cnt_reg;
  logic             err_stray_reg;
  logic             cmp_rst_reg;
  logic             cmp_valid_in_reg;
  logic [15:0]      cmp_pixel_in_reg;

  logic             out_valid_reg, out_valid_next;
  logic [31:0]      out_data_reg,  out_data_next;
  logic             out_sof_reg,   out_sof_next;
  logic             out_eof_reg,   out_eof_next;

  logic in_payload;
  logic pix_accept;
  logic last_pix;
  logic drain_done;
  logic trailer_end;

`ifdef LWIR_CTRL_CHECKSUM_EN
  logic        trl_idx_reg;
  logic [31:0] sum_reg;
`endif

  assign src_ready  = (state_reg == STREAM);
  assign in_payload = (state_reg == STREAM) || (state_reg == DRAIN);
  assign pix_accept = src_valid && src_ready;
  assign last_pix   = (pix_cnt_reg == LAST_PIX);
  assign busy       = (state_reg != IDLE);

`ifdef LWIR_CTRL_CHECKSUM_EN
  assign trailer_end = (state_reg == TRAILER) && trl_idx_reg;
`else
  assign trailer_end = (state_reg == TRAILER);
`endif

  lwir_idle_timer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg != DRAIN),
    .enable (state_reg == DRAIN),
    .valid  (cmp_valid_out),
    .done   (drain_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    out_valid_next = 1'b0;
    out_data_next  = '0;
    out_sof_next   = 1'b0;
    out_eof_next   = 1'b0;

    // Core words are forwarded only while a frame is open; elsewhere they are strays.
    if (in_payload && cmp_valid_out) begin
      out_valid_next = 1'b1;
      out_data_next  = cmp_stream_out;
    end

    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_reg == LAST_CLR) state_next = HEADER;
      end
      HEADER: begin
        out_valid_next = 1'b1;
        out_data_next  = make_header(MAGIC, frame_cnt_reg);
        out_sof_next   = 1'b1;
        state_next     = STREAM;
      end
      STREAM: begin
        if (pix_accept && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = TRAILER;
      end
      TRAILER: begin
        out_valid_next = 1'b1;
`ifdef LWIR_CTRL_CHECKSUM_EN
        if (!trl_idx_reg) begin
          out_data_next = pay_cnt_reg;
        end else begin
          out_data_next = sum_reg;
          out_eof_next  = 1'b1;
          state_next    = IDLE;
        end
`else
        out_data_next = pay_cnt_reg;
        out_eof_next  = 1'b1;
        state_next    = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_cnt_reg      <= '0;
      pix_cnt_reg      <= '0;
      pay_cnt_reg      <= '0;
      frame_cnt_reg    <= '0;
      err_stray_reg    <= 1'b0;
      cmp_rst_reg      <= 1'b1;
      cmp_valid_in_reg <= 1'b0;
      cmp_pixel_in_reg <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_sof_reg      <= 1'b0;
      out_eof_reg      <= 1'b0;
    end else begin
      // Registered from the next state so the core reset spans exactly the CLEAR cycles.
      cmp_rst_reg <= (state_next == CLEAR);
      clr_cnt_reg <= (state_reg == CLEAR) ? clr_cnt_reg + CLR_W'(1) : '0;

      cmp_valid_in_reg <= pix_accept;
      if (pix_accept) begin
        cmp_pixel_in_reg <= src_pixel;
        pix_cnt_reg      <= last_pix ? '0 : pix_cnt_reg + PIX_W'(1);
      end

      if (in_payload && cmp_valid_out && (pay_cnt_reg != 32'hFFFF_FFFF)) begin
        pay_cnt_reg <= pay_cnt_reg + 32'd1;
      end

      if (!in_payload && cmp_valid_out) begin
        err_stray_reg <= 1'b1;
      end

      if (trailer_end) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
        pay_cnt_reg   <= '0;
      end

      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sof_reg   <= out_sof_next;
      out_eof_reg   <= out_eof_next;
    end
  end

`ifdef LWIR_CTRL_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      trl_idx_reg <= 1'b0;
      sum_reg     <= '0;
    end else begin
      trl_idx_reg <= (state_reg == TRAILER) ? !trl_idx_reg : 1'b0;
      if (trailer_end) begin
        sum_reg <= '0;
      end else if (in_payload && cmp_valid_out) begin
        sum_reg <= sum_reg + cmp_stream_out;
      end
    end
  end
`endif

  assign cmp_rst      = cmp_rst_reg;
  assign cmp_valid_in = cmp_valid_in_reg;
  assign cmp_pixel_in = cmp_pixel_in_reg;
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_sof      = out_sof_reg;
  assign out_eof      = out_eof_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign err_stray    = err_stray_reg;

endmodule
